// File: rtl/spi_reg_slave_pkg.sv
// Shared constants, status bit positions and FSM encoding for the SPI
// register responder.
package spi_reg_slave_pkg;

   localparam logic [7:0] CMD_WRITE = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;

   localparam int STAT_BAD_CMD  = 0;
   localparam int STAT_ABORT    = 1;
   localparam int STAT_TIMEOUT  = 2;
   localparam int STAT_MISALIGN = 3;

   // Index of the last bit of each frame field (bit 0 is the first bit sent).
   localparam logic [5:0] CMD_LAST_BIT  = 6'd7;
   localparam logic [5:0] ADDR_LAST_BIT = 6'd23;
   localparam logic [5:0] DATA_LAST_BIT = 6'd55;
   localparam logic [5:0] STAT_LAST_BIT = 6'd63;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_STAT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the asynchronous SPI pins into clk and flags the SCK and
// SS_N edges used by the frame decoder.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic spi_sck,
   input  logic spi_ss_n,
   input  logic spi_mosi,
   output logic sck_rise,
   output logic sck_fall,
   output logic ss_fall,
   output logic ss_rise,
   output logic mosi_s
);

   logic [SYNC_STAGES-1:0] sck_q;
   logic [SYNC_STAGES-1:0] ss_q;
   logic [SYNC_STAGES-1:0] mosi_q;
   logic                   sck_d;
   logic                   ss_d;

   // ss_n resets to "selected" so a frame already in progress when reset is
   // released produces no falling edge; only a fresh high-then-low starts one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sck_q  <= '0;
         ss_q   <= '0;
         mosi_q <= '0;
         sck_d  <= 1'b0;
         ss_d   <= 1'b0;
      end else begin
         sck_q  <= (sck_q << 1) | SYNC_STAGES'(spi_sck);
         ss_q   <= (ss_q << 1) | SYNC_STAGES'(spi_ss_n);
         mosi_q <= (mosi_q << 1) | SYNC_STAGES'(spi_mosi);
         sck_d  <= sck_q[SYNC_STAGES-1];
         ss_d   <= ss_q[SYNC_STAGES-1];
      end
   end

   assign sck_rise = sck_q[SYNC_STAGES-1] & ~sck_d;
   assign sck_fall = ~sck_q[SYNC_STAGES-1] & sck_d;
   assign ss_rise  = ss_q[SYNC_STAGES-1] & ~ss_d;
   assign ss_fall  = ~ss_q[SYNC_STAGES-1] & ss_d;
   assign mosi_s   = mosi_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder: decodes a 64-bit cmd/addr/data/stat frame into one
// register-bus access and shifts read data plus a status byte back on MISO.
module spi_reg_slave
   import spi_reg_slave_pkg::*;
#(
   parameter int AW          = 16,
   parameter int DW          = 32,
   parameter int ACK_TIMEOUT = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          spi_sck,
   input  logic          spi_ss_n,
   input  logic          spi_mosi,
   output logic          spi_miso,
   output logic          reg_req,
   output logic          reg_we,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   input  logic          reg_ack,
   input  logic [DW-1:0] reg_rdata
);

   localparam int RXW = 8 + AW + DW;
   localparam int CW  = $clog2(ACK_TIMEOUT + 1);

   logic           sck_rise, sck_fall, ss_fall, ss_rise, mosi_s;
   state_t         state, state_nx;
   logic [5:0]     bit_cnt;
   logic [RXW-1:0] rx_sr, rx_next;
   logic [7:0]     cmd_q;
   logic [DW-1:0]  tx_sr;
   logic           rd_pend;
   logic [CW-1:0]  ack_cnt;
   logic           abort_flag, rep_abort, stat_bad, stat_to, stat_mis;
   logic [7:0]     stat_byte;
   logic           start, sample, abort, issue_read, issue_write;

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rstn     (rstn),
      .spi_sck  (spi_sck),
      .spi_ss_n (spi_ss_n),
      .spi_mosi (spi_mosi),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .ss_fall  (ss_fall),
      .ss_rise  (ss_rise),
      .mosi_s   (mosi_s)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE: if (ss_fall) state_nx = ST_CMD;
         ST_CMD:  if (ss_rise) state_nx = ST_IDLE;
                  else if (sck_rise && bit_cnt == CMD_LAST_BIT) state_nx = ST_ADDR;
         ST_ADDR: if (ss_rise) state_nx = ST_IDLE;
                  else if (sck_rise && bit_cnt == ADDR_LAST_BIT) state_nx = ST_DATA;
         ST_DATA: if (ss_rise) state_nx = ST_IDLE;
                  else if (sck_rise && bit_cnt == DATA_LAST_BIT) state_nx = ST_STAT;
         ST_STAT: if (ss_rise) state_nx = ST_IDLE;
                  else if (sck_rise && bit_cnt == STAT_LAST_BIT) state_nx = ST_DONE;
         ST_DONE: if (ss_rise) state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      start       = ss_fall && (state == ST_IDLE);
      sample      = sck_rise && (state inside {ST_CMD, ST_ADDR, ST_DATA, ST_STAT});
      abort       = ss_rise && (state inside {ST_CMD, ST_ADDR, ST_DATA, ST_STAT});
      issue_read  = sample && (state == ST_ADDR) && (bit_cnt == ADDR_LAST_BIT)
                    && (cmd_q == CMD_READ);
      issue_write = sample && (state == ST_DATA) && (bit_cnt == DATA_LAST_BIT)
                    && (cmd_q == CMD_WRITE);
   end

   assign rx_next = {rx_sr[RXW-2:0], mosi_s};

   always_comb begin
      stat_byte                = '0;
      stat_byte[STAT_BAD_CMD]  = stat_bad;
      stat_byte[STAT_ABORT]    = rep_abort;
      stat_byte[STAT_TIMEOUT]  = stat_to;
      stat_byte[STAT_MISALIGN] = stat_mis;
   end

   // The sticky abort is handed to the next frame at its start and cleared;
   // if that frame is itself aborted the flag is simply set again.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bit_cnt    <= '0;
         rx_sr      <= '0;
         cmd_q      <= '0;
         stat_bad   <= 1'b0;
         stat_mis   <= 1'b0;
         rep_abort  <= 1'b0;
         abort_flag <= 1'b0;
      end else begin
         if (start) begin
            bit_cnt    <= '0;
            stat_bad   <= 1'b0;
            stat_mis   <= 1'b0;
            rep_abort  <= abort_flag;
            abort_flag <= 1'b0;
         end else if (sample) begin
            bit_cnt <= bit_cnt + 6'd1;
            rx_sr   <= rx_next;
            if (state == ST_CMD && bit_cnt == CMD_LAST_BIT) begin
               cmd_q    <= rx_next[7:0];
               stat_bad <= !(rx_next[7:0] inside {CMD_WRITE, CMD_READ});
            end
            if (state == ST_ADDR && bit_cnt == ADDR_LAST_BIT)
               stat_mis <= |rx_next[1:0];
         end
         if (abort) abort_flag <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         reg_req   <= 1'b0;
         reg_we    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
      end else begin
         reg_req <= issue_read || issue_write;
         if (issue_read) begin
            reg_we   <= 1'b0;
            reg_addr <= rx_next[AW-1:0];
         end else if (issue_write) begin
            reg_we    <= 1'b1;
            reg_addr  <= rx_next[DW+AW-1:DW];
            reg_wdata <= rx_next[DW-1:0];
         end
      end
   end

   // Read data must land before the first data falling edge, so a pending
   // read never overlaps shifting.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rd_pend <= 1'b0;
         ack_cnt <= '0;
         stat_to <= 1'b0;
         tx_sr   <= '0;
      end else if (start) begin
         rd_pend <= 1'b0;
         stat_to <= 1'b0;
         tx_sr   <= '0;
      end else if (ss_rise) begin
         rd_pend <= 1'b0;
      end else if (issue_read) begin
         rd_pend <= 1'b1;
         ack_cnt <= '0;
      end else if (rd_pend && reg_ack) begin
         rd_pend <= 1'b0;
         tx_sr   <= reg_rdata;
      end else if (rd_pend && ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
         rd_pend <= 1'b0;
         stat_to <= 1'b1;
      end else if (rd_pend) begin
         ack_cnt <= ack_cnt + CW'(1);
      end else if (sck_fall && state == ST_DATA) begin
         tx_sr <= {tx_sr[DW-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         spi_miso <= 1'b0;
      end else if (ss_rise || state == ST_IDLE) begin
         spi_miso <= 1'b0;
      end else if (sck_fall) begin
         if (state == ST_DATA)      spi_miso <= tx_sr[DW-1];
         else if (state == ST_STAT) spi_miso <= stat_byte[3'd7 - bit_cnt[2:0]];
         else                       spi_miso <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: host SPI driver, register responder and a
// scoreboard fed by a frame-level model of the expected bus and MISO traffic.
module tb_spi_reg_slave;
   import spi_reg_slave_pkg::*;

   localparam int AW          = 16;
   localparam int DW          = 32;
   localparam int ACK_TIMEOUT = 12;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 20;

   logic          clk      = 1'b0;
   logic          rstn     = 1'b0;
   logic          spi_sck  = 1'b0;
   logic          spi_ss_n = 1'b1;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic          reg_req;
   logic          reg_we;
   logic [AW-1:0] reg_addr;
   logic [DW-1:0] reg_wdata;
   logic          reg_ack;
   logic [DW-1:0] reg_rdata;

   int n_chk = 0;
   int n_err = 0;

   logic [AW+DW:0] exp_bus_q[$];
   logic [63:0]    exp_miso_q[$];
   logic [63:0]    got_q[$];
   logic [AW+DW:0] bus_e;
   logic [63:0]    got_w, exp_w;

   int            ack_dly     = -1;   // -1 no ack, -2 late ack, else delay
   logic [DW-1:0] rd_cfg      = '0;
   bit            spur_en     = 1'b0;
   bit            model_abort = 1'b0;

   spi_reg_slave #(
      .AW(AW), .DW(DW), .ACK_TIMEOUT(ACK_TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .spi_sck   (spi_sck),
      .spi_ss_n  (spi_ss_n),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .reg_req   (reg_req),
      .reg_we    (reg_we),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_ack   (reg_ack),
      .reg_rdata (reg_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Register-file responder: acks reads after ack_dly cycles, drives junk
   // rdata otherwise, and throws stray acks during non-read frames.
   initial begin : responder
      int d;
      reg_ack   = 1'b0;
      reg_rdata = '0;
      forever begin
         @(negedge clk);
         reg_ack   = 1'b0;
         reg_rdata = DW'($urandom);
         if (rstn && reg_req && !reg_we && ack_dly != -1) begin
            d = (ack_dly == -2) ? ACK_TIMEOUT + 2 : ack_dly;
            repeat (d) begin
               @(negedge clk);
               reg_rdata = DW'($urandom);
            end
            reg_ack   = 1'b1;
            reg_rdata = rd_cfg;
         end else if (spur_en && $urandom_range(0, 99) < 3) begin
            reg_ack = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rstn && reg_req) begin
         if (exp_bus_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL bus_unexpected_req: got req we=%b addr=%h, expected no request",
                     reg_we, reg_addr);
         end else begin
            bus_e = exp_bus_q.pop_front();
            check("bus_we", 64'(reg_we), 64'(bus_e[AW+DW]));
            check("bus_addr", 64'(reg_addr), 64'(bus_e[AW+DW-1:DW]));
            if (bus_e[AW+DW]) check("bus_wdata", 64'(reg_wdata), 64'(bus_e[DW-1:0]));
         end
      end
   end

   always @(negedge clk) begin
      if (got_q.size() > 0) begin
         got_w = got_q.pop_front();
         if (exp_miso_q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL miso_unexpected_frame: got %h, expected no frame", got_w);
         end else begin
            exp_w = exp_miso_q.pop_front();
            check("miso_header", 64'(got_w[63:40]), 64'(exp_w[63:40]));
            check("miso_data", 64'(got_w[39:8]), 64'(exp_w[39:8]));
            check("miso_stat", 64'(got_w[7:0]), 64'(exp_w[7:0]));
         end
      end
   end

   // Host side of one frame; nbits < 64 aborts, rst_bit >= 0 pulses reset.
   task automatic spi_frame(input logic [7:0] cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int nbits, input int rst_bit);
      logic [63:0] tx, rx;
      logic [7:0]  stat;
      bit          full, is_w, is_r, acked;
      tx    = {cmd, addr, data, 8'h00};
      rx    = '0;
      full  = (nbits == 64) && (rst_bit < 0);
      is_w  = (cmd == CMD_WRITE);
      is_r  = (cmd == CMD_READ);
      acked = is_r && (ack_dly >= 0);
      if (full) begin
         stat    = '0;
         stat[0] = !(is_w || is_r);
         stat[1] = model_abort;
         stat[2] = is_r && !acked;
         stat[3] = (addr[1:0] != 2'b00);
         exp_miso_q.push_back({24'h0, (acked ? rd_cfg : 32'h0), stat});
         if (is_w) exp_bus_q.push_back({1'b1, addr, data});
         if (is_r) exp_bus_q.push_back({1'b0, addr, 32'h0});
         model_abort = 1'b0;
      end else if (rst_bit >= 0) begin
         exp_miso_q.push_back(64'h0);
         model_abort = 1'b0;
      end else begin
         model_abort = 1'b1;
      end
      spur_en  = !is_r;
      spi_ss_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         if (i == rst_bit) begin
            rstn = 1'b0;
            @(negedge clk);
            check("rst_reg_req", 64'(reg_req), 64'h0);
            check("rst_reg_addr", 64'(reg_addr), 64'h0);
            check("rst_reg_wdata", 64'(reg_wdata), 64'h0);
            check("rst_miso", 64'(spi_miso), 64'h0);
            rstn = 1'b1;
         end
         spi_mosi = tx[63-i];
         repeat (HALF) @(negedge clk);
         spi_sck   = 1'b1;
         rx[63-i]  = spi_miso;
         repeat (HALF) @(negedge clk);
         spi_sck = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      spi_ss_n = 1'b1;
      spur_en  = 1'b0;
      if (full || rst_bit >= 0) got_q.push_back(rx);
      repeat (2 * HALF) @(negedge clk);
   endtask

   initial begin : watchdog
      repeat (95000) @(negedge clk);
      n_err++;
      $display("FAIL watchdog: bench still running after 95000 cycles, expected completion");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [7:0]    c;
      logic [AW-1:0] a;
      logic [DW-1:0] dd;
      int            k;
      rstn = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_miso", 64'(spi_miso), 64'h0);
      check("reset_reg_req", 64'(reg_req), 64'h0);
      check("reset_reg_we", 64'(reg_we), 64'h0);
      check("reset_reg_addr", 64'(reg_addr), 64'h0);
      check("reset_reg_wdata", 64'(reg_wdata), 64'h0);
      rstn = 1'b1;
      repeat (10) @(negedge clk);

      ack_dly = -1;
      spi_frame(CMD_WRITE, 16'h0010, 32'h12345678, 64, -1);
      rd_cfg  = 32'hCAFEF00D;
      ack_dly = 10;
      spi_frame(CMD_READ, 16'h0024, 32'h0, 64, -1);
      ack_dly = -1;
      spi_frame(CMD_READ, 16'h0024, 32'h0, 64, -1);
      spi_frame(CMD_WRITE, 16'h0040, 32'hA5A50001, 20, -1);
      spi_frame(CMD_WRITE, 16'h0044, 32'h0BADBEEF, 64, -1);
      spi_frame(CMD_WRITE, 16'h0048, 32'h00C0FFEE, 64, -1);
      spi_frame(8'h7F, 16'h0008, 32'h11112222, 64, -1);
      rd_cfg  = 32'h5EED1234;
      ack_dly = 3;
      spi_frame(CMD_READ, 16'h0013, 32'h0, 64, -1);
      ack_dly = -1;
      spi_frame(CMD_WRITE, 16'h0050, 32'hDEADBEEF, 64, 40);
      spi_frame(CMD_WRITE, 16'h0054, 32'h87654321, 64, -1);

      for (int n = 0; n < 12; n++) begin
         k  = $urandom_range(0, 9);
         a  = AW'($urandom);
         dd = DW'($urandom);
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         if (k <= 3) begin
            spi_frame(CMD_WRITE, a, dd, 64, -1);
         end else if (k <= 7) begin
            rd_cfg = DW'($urandom);
            k      = $urandom_range(0, 8);
            if (k <= 6)      ack_dly = $urandom_range(0, ACK_TIMEOUT - 3);
            else if (k == 7) ack_dly = -1;
            else             ack_dly = -2;
            spi_frame(CMD_READ, a, dd, 64, -1);
            ack_dly = -1;
         end else if (k == 8) begin
            c = 8'($urandom_range(3, 255));
            spi_frame(c, a, dd, 64, -1);
         end else begin
            c = 8'($urandom);
            spi_frame(c, a, dd, $urandom_range(1, 23), -1);
         end
      end

      repeat (20) @(negedge clk);
      check("exp_bus_q_drained", 64'(exp_bus_q.size()), 64'h0);
      check("exp_miso_q_drained", 64'(exp_miso_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI responder that terminates the host-side SPI link of the FourierTransform top level and converts each SPI frame into one register-bus access. It oversamples the SPI pins in the `clk` domain and decodes a fixed 64-bit frame: command, address, data, status. It issues single-cycle write or read requests to the register file (RESET_ALL, FREQ_n, NUM_SAMP, SAMP_FREQ, STATUS, DATA_n, ...). Read data and a per-frame status byte are shifted back on MISO.

## Interface
- `AW`, 16: register address width
- `DW`, 32: register data width
- `ACK_TIMEOUT`, 64: clk cycles allowed between `reg_req` and `reg_ack` on a read
- `SYNC_STAGES`, 2: synchronizer depth on `spi_sck`, `spi_ss_n`, `spi_mosi`
- `clk` in 1: system clock; all logic on its rising edge
- `rstn` in 1: reset, asynchronous and active-low
- `spi_sck` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0), async to `clk`
- `spi_ss_n` in 1: active-low frame select
- `spi_mosi` in 1: host data, MSB first
- `spi_miso` out 1: responder data, MSB first; 0 while `spi_ss_n` is high
- `reg_req` out 1: one-cycle access strobe
- `reg_we` out 1: 1 = write, 0 = read; valid with `reg_req`
- `reg_addr` out AW: access address; valid with `reg_req`
- `reg_wdata` out DW: write data; valid with `reg_req`
- `reg_ack` in 1: one-cycle completion; carries `reg_rdata` on reads
- `reg_rdata` in DW: read data, sampled when `reg_ack` is 1

## Operation
- Frame, 64 SCK periods, MSB first: cmd[7:0], addr[15:0], data[31:0], stat[7:0].
- Commands:
  - 0x01 WRITE
  - 0x02 READ
  - any other value is BAD_CMD: no bus access and stat bit0 set.
- MOSI is sampled on the synchronized SCK rising edge. MISO is updated on the synchronized SCK falling edge.
- FSM states:
  - IDLE → CMD on `ss_n` falling edge.
  - CMD → ADDR after bit 7.
  - ADDR → DATA after bit 23.
  - DATA → STAT after bit 55.
  - STAT → DONE after bit 63.
  - DONE → IDLE on `ss_n` rising edge.
  - `ss_n` rising in any state other than IDLE or DONE is an abort: go to IDLE, issue no bus access, set the sticky abort flag.
- A 6-bit bit counter resets to 0 on `ss_n` falling edge and increments on each sampled rising edge.
- READ:
  - `reg_req` (we=0) is issued one clk after bit 23 is sampled.
  - The first `reg_ack` within ACK_TIMEOUT cycles loads `reg_rdata` into the shift register; the MSB is driven from the next SCK falling edge.
  - If no ack arrives, shift out 0 and set stat bit2.
  - `reg_ack` outside a pending read is ignored.
- WRITE: `reg_req` (we=1) with addr/wdata is issued one clk after bit 55 is sampled. The write does not wait for `reg_ack`.
- On WRITE, MISO carries 0 during cmd/addr/data.
- Status byte, driven during bits 56–63:
  - bit0: BAD_CMD
  - bit1: previous frame aborted (sticky; cleared after it is reported)
  - bit2: read timeout
  - bit3: addr[1:0] ≠ 0; the access is still performed
  - bits 7:4: 0
- Reset values: `spi_miso` 0, `reg_req` 0, `reg_we` 0, `reg_addr` 0, `reg_wdata` 0; FSM IDLE; sticky abort flag 0.
- Reset asserted mid-frame: return to IDLE at once. The remainder of that frame is ignored until `ss_n` goes high and then low again.

## Timing
- Input-to-edge latency is SYNC_STAGES + 1 clk.
- SCK half-period must be ≥ 8 clk cycles. Nominal is 1 µs SCK with 5 ns clk.
- READ deadline: ack must arrive before the bit-23 falling edge minus 2 clk, otherwise it counts as a timeout. ACK_TIMEOUT is sized inside that window.
- At most one `reg_req` per frame; `reg_req` is high for exactly one clk.
- MISO changes only on synchronized falling edges, or goes to 0 on `ss_n` high.

## Structure
- `spi_reg_slave_pkg`:
  - CMD_WRITE/CMD_READ constants
  - STAT_* bit indices
  - FSM state enum (IDLE, CMD, ADDR, DATA, STAT, DONE)
  - frame field offsets
- Sub-module `spi_pin_sync`: SYNC_STAGES flops per pin plus rise/fall detect for sck and ss_n. Outputs `sck_rise`, `sck_fall`, `ss_fall`, `ss_rise`, `mosi_s`.

## Test plan
- WRITE 0x12345678 to 0x0010 → single `reg_req` with we=1, addr 0x0010, wdata 0x12345678; stat 0x00; MISO 0 during data.
- READ 0x0024, `reg_ack` 10 clks after `reg_req` with rdata 0xCAFEF00D → MISO shifts 0xCAFEF00D; stat 0x00.
- READ 0x0024 with no `reg_ack` → MISO data 0x00000000; stat 0x04; bus idle afterwards.
- Frame aborted after 20 bits (`ss_n` high) → no `reg_req`. The next valid WRITE returns stat 0x02, the one after that 0x00.
- cmd 0x7F → no `reg_req`; stat 0x01. READ at 0x0013 → access performed; stat 0x08.
- `rstn` pulsed low at bit 40 of a WRITE → no `reg_req`, MISO 0. The following full frame completes normally.
